hazard_control_unit: RTL and testbench

//  Counterpart of the D->E pipeline register: consumes its E-stage outputs (Rs1E/Rs2E/RdE/ResultSrcE) plus M/W state,
//  and drives the stall/flush controls that feed back into F, D and E registers (FlushE is the E register's clr).

---
 rtl/hazard_control_unit.sv | 169 ++++++++++++++++
 tb/tb_hazard_control_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Hazard control: forwarding, load-use stall, branch flush, data-memory wait FSM.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       Rs1D,
  input  logic [2:0]       Rs2D,
  input  logic [2:0]       Rs1E,
  input  logic [2:0]       Rs2E,
  input  logic [2:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [2:0]       RdM,
  input  logic [2:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             mem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] cnt_lwstall,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_memwait
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          err_set;
  logic          lwstall;
  logic          enter_wait;
  logic          fam, faw, fbm, fbw;

  assign lwstall = (ResultSrcE == 2'b01) && (RdE != 3'd0)
                && ((RdE == Rs1D) || (RdE == Rs2D));
  assign enter_wait = MemReqM && !mem_ready;

  // M match wins; W terms are masked so the decoders stay one-hot
  assign fam = !rst && RegWriteM && (RdM != 3'd0) && (RdM == Rs1E);
  assign fbm = !rst && RegWriteM && (RdM != 3'd0) && (RdM == Rs2E);
  assign faw = !rst && !fam && RegWriteW && (RdW != 3'd0)
            && (RdW == Rs1E);
  assign fbw = !rst && !fbm && RegWriteW && (RdW != 3'd0)
            && (RdW == Rs2E);

  always_comb begin
    unique case (1'b1)
      fam:     ForwardAE = 2'b10;
      faw:     ForwardAE = 2'b01;
      default: ForwardAE = 2'b00;
    endcase
    unique case (1'b1)
      fbm:     ForwardBE = 2'b10;
      fbw:     ForwardBE = 2'b01;
      default: ForwardBE = 2'b00;
    endcase
  end

  always_comb begin
    state_nx = state;
    tcnt_nx  = '0;
    err_set  = 1'b0;
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushW   = 1'b0;
    if (rst) begin
      FlushD   = 1'b1;
      FlushE   = 1'b1;
      FlushW   = 1'b1;
      state_nx = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (enter_wait) begin
            StallF   = 1'b1;
            StallD   = 1'b1;
            StallE   = 1'b1;
            StallM   = 1'b1;
            FlushW   = 1'b1;
            state_nx = MEM_WAIT;
          end else begin
            StallF = lwstall;
            StallD = lwstall;
            FlushD = PCSrcE;
            FlushE = lwstall || PCSrcE;
          end
        end
        MEM_WAIT: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          if (mem_ready) begin
            state_nx = RUN;
          end else if (tcnt == TLAST) begin
            FlushW   = 1'b1;
            err_set  = 1'b1;
            state_nx = RUN;
          end else begin
            FlushW  = 1'b1;
            tcnt_nx = tcnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      tcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nx;
      tcnt  <= tcnt_nx;
      if (err_set) mem_err <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic wait_cyc;

  // a cycle that enters the wait already behaves as a wait cycle
  assign wait_cyc = (state == MEM_WAIT) || enter_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lwstall <= '0;
      cnt_flush   <= '0;
      cnt_memwait <= '0;
    end else begin
      if (!wait_cyc && lwstall && cnt_lwstall != CMAX)
        cnt_lwstall <= cnt_lwstall + 1'b1;
      if (!wait_cyc && PCSrcE && cnt_flush != CMAX)
        cnt_flush <= cnt_flush + 1'b1;
      if (wait_cyc && cnt_memwait != CMAX)
        cnt_memwait <= cnt_memwait + 1'b1;
    end
  end
`else
  assign cnt_lwstall = '0;
  assign cnt_flush   = '0;
  assign cnt_memwait = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed cases then random traffic
// against a cycle-level behavioural model.
module tb_hazard_control_unit;
  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0;
  logic [1:0]    ResultSrcE = '0;
  logic          PCSrcE = 1'b0;
  logic [2:0]    RdM = '0, RdW = '0;
  logic          RegWriteM = 1'b0, RegWriteW = 1'b0;
  logic          MemReqM = 1'b0, mem_ready = 1'b0;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          mem_err;
  logic [CW-1:0] cnt_lwstall, cnt_flush, cnt_memwait;

  hazard_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .mem_ready(mem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_err(mem_err),
    .cnt_lwstall(cnt_lwstall), .cnt_flush(cnt_flush),
    .cnt_memwait(cnt_memwait)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [2:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic [1:0] rsrc;
    logic       pcsrc;
    logic [2:0] rdm, rdw;
    logic       rwm, rww, mreq, mrdy;
  } stim_t;

  typedef struct packed {
    logic [10:0]     ctrl;
    logic            err;
    logic [3*CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;

  // reference model state: pipeline held for memory, cycles waited, counters
  bit   m_wait = 0;
  int   m_waited = 0;
  bit   m_err = 0;
  int   c_lw = 0, c_fl = 0, c_mw = 0;

  function automatic int sat(input int v);
    return (v + 1 > CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [1:0] fwd(input stim_t s, input logic [2:0] rs);
    if (s.rwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
    if (s.rww && s.rdw != 0 && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step(input stim_t s);
    exp_t       e;
    logic       lw, hold;
    logic       sf, sd, se, sm, fd, fe, fw;
    logic [1:0] fa, fb;
    @(posedge clk);
    #1;
    rst = s.rst; Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e;
    Rs2E = s.rs2e; RdE = s.rde; ResultSrcE = s.rsrc; PCSrcE = s.pcsrc;
    RdM = s.rdm; RdW = s.rdw; RegWriteM = s.rwm; RegWriteW = s.rww;
    MemReqM = s.mreq; mem_ready = s.mrdy;
    lw = (s.rsrc == 2'b01) && s.rde != 0
      && (s.rde == s.rs1d || s.rde == s.rs2d);
    hold = m_wait || (s.mreq && !s.mrdy);
    {sf, sd, se, sm, fd, fe, fw} = '0;
    fa = 2'b00;
    fb = 2'b00;
    if (s.rst) begin
      {fd, fe, fw} = 3'b111;
    end else begin
      fa = fwd(s, s.rs1e);
      fb = fwd(s, s.rs2e);
      if (hold) begin
        {sf, sd, se, sm} = 4'b1111;
        fw = !(m_wait && s.mrdy);
      end else begin
        sf = lw;
        sd = lw;
        fd = s.pcsrc;
        fe = lw || s.pcsrc;
      end
    end
    e.ctrl = {sf, sd, se, sm, fd, fe, fw, fa, fb};
    e.err  = m_err;
`ifdef HAZARD_PERF_CNT_EN
    e.cnt = {CW'(c_lw), CW'(c_fl), CW'(c_mw)};
`else
    e.cnt = '0;
`endif
    q.push_back(e);
    if (s.rst) begin
      m_wait = 0; m_waited = 0; m_err = 0;
      c_lw = 0; c_fl = 0; c_mw = 0;
    end else if (hold) begin
      c_mw = sat(c_mw);
      if (!m_wait) begin
        m_wait = 1;
        m_waited = 0;
      end else if (s.mrdy) begin
        m_wait = 0;
      end else if (m_waited == TO - 1) begin
        m_wait = 0;
        m_err = 1;
      end else begin
        m_waited++;
      end
    end else begin
      if (lw) c_lw = sat(c_lw);
      if (s.pcsrc) c_fl = sat(c_fl);
    end
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [10:0] act;
    if (q.size() != 0) begin
      e = q.pop_front();
      act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             ForwardAE, ForwardBE};
      compared++;
      if (act !== e.ctrl) begin
        mismatched++;
        $display("FAIL ctrl t=%0t got=%b want=%b", $time, act, e.ctrl);
      end
      compared++;
      if (mem_err !== e.err) begin
        mismatched++;
        $display("FAIL mem_err t=%0t got=%b want=%b", $time, mem_err, e.err);
      end
      compared++;
      if ({cnt_lwstall, cnt_flush, cnt_memwait} !== e.cnt) begin
        mismatched++;
        $display("FAIL counters t=%0t got=%h want=%h", $time,
                 {cnt_lwstall, cnt_flush, cnt_memwait}, e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    repeat (2) @(posedge clk);
    // reset held, then idle
    s = '0; s.rst = 1'b1;
    step(s); step(s);
    s = '0;
    step(s); step(s);
    // forwarding M beats W, then W alone, x0 never
    s.rwm = 1; s.rdm = 3; s.rww = 1; s.rdw = 3; s.rs1e = 3; s.rs2e = 0;
    step(s);
    s.rdm = 0;
    step(s);
    s.rs2e = 3; s.rdw = 0;
    step(s);
    // load-use, then load to x0
    s = '0; s.rsrc = 2'b01; s.rde = 5; s.rs2d = 5;
    step(s);
    s.rde = 0;
    step(s);
    // load-use together with taken branch
    s.rde = 5; s.pcsrc = 1;
    step(s);
    // memory wait: three not-ready cycles then ready
    s = '0; s.mreq = 1;
    repeat (3) step(s);
    s.mrdy = 1;
    step(s);
    s = '0;
    step(s);
    // timeout with branch pending, mem_err sticky until reset
    s.mreq = 1; s.pcsrc = 1;
    repeat (TO + 1) step(s);
    s = '0;
    repeat (3) step(s);
    s.rst = 1;
    step(s);
    s = '0;
    step(s);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      s.rst   = ($urandom_range(0, 79) == 0);
      s.rs1d  = 3'($urandom_range(0, 3));
      s.rs2d  = 3'($urandom_range(0, 3));
      s.rs1e  = 3'($urandom_range(0, 3));
      s.rs2e  = 3'($urandom_range(0, 3));
      s.rde   = 3'($urandom_range(0, 3));
      s.rdm   = 3'($urandom_range(0, 3));
      s.rdw   = 3'($urandom_range(0, 3));
      s.rsrc  = 2'($urandom_range(0, 3));
      s.pcsrc = ($urandom_range(0, 3) == 0);
      s.rwm   = 1'($urandom_range(0, 1));
      s.rww   = 1'($urandom_range(0, 1));
      s.mreq  = ($urandom_range(0, 2) == 0);
      s.mrdy  = ($urandom_range(0, 9) < 3);
      step(s);
    end
    @(negedge clk);
    #1;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
